// File: rtl/apb_slave_regfile.sv
// Zero-wait-state APB completer: register file with combinational read data, an APB
// phase-tracking FSM, saturating write/read counters and a sticky protocol-error flag.
`timescale 1ns/1ps
module apb_slave_regfile #(
    parameter int SEL_IDX  = 0,
    parameter int NUM_REGS = 16,
    parameter int ADDR_LSB = 2
) (
    input  logic        Pclk,
    input  logic        Preset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        proto_err
);
    localparam int IW     = $clog2(NUM_REGS);
    localparam int HI_LSB = ADDR_LSB + IW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sel;
    logic            hit;
    logic [IW-1:0]   idx;
    logic [31:0]     addr_q, addr_d;
    logic            wr_q, wr_d;
    logic            latch;
    logic            commit;
    logic            err_set;
    logic            proto_err_q;
    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic [15:0]     rd_cnt_q, rd_cnt_d;
    logic [NUM_REGS-1:0] reg_we;
    logic [31:0]     regs_q [NUM_REGS];
    logic            unused_bits;

    assign sel = Pselx[SEL_IDX];
    assign idx = Paddr[ADDR_LSB +: IW];
    assign hit = (Paddr[31:HI_LSB] == '0);

    // Only one select bit and the indexed/upper address bits matter here.
    assign unused_bits = ^{Pselx, Paddr};

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        commit  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !Penable) begin
                    state_d = SETUP;
                    latch   = 1'b1;
                end else if (sel && Penable) begin
                    err_set = 1'b1;
                end
            end
            SETUP: begin
                if (sel && Penable) begin
                    if (Paddr == addr_q && Pwrite == wr_q) begin
                        commit  = 1'b1;
                        state_d = ACCESS;
                    end else begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end
                end else if (sel) begin
                    // Re-issued setup phase restarts the transfer with fresh attributes.
                    latch = 1'b1;
                end else begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (sel && !Penable) begin
                    state_d = SETUP;
                    latch   = 1'b1;
                end else if (sel && Penable) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_d = latch ? Paddr  : addr_q;
    assign wr_d   = latch ? Pwrite : wr_q;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign reg_we[gi] = commit && wr_q && hit && (idx == IW'(gi));
        end
    endgenerate

    always_ff @(posedge Pclk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (Preset) begin
                regs_q[i] <= '0;
            end else if (reg_we[i]) begin
                regs_q[i] <= Pwdata;
            end
        end
    end

    // Counters count every committed transfer, hit or miss, and stick at all-ones.
    assign wr_cnt_d = (commit && wr_q && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
    assign rd_cnt_d = (commit && !wr_q && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            proto_err_q <= proto_err_q | err_set;
        end
    end

    always_comb begin
        Prdata = '0;
        if (state_q == SETUP && sel && Penable && !Pwrite && hit) begin
            Prdata = regs_q[idx];
        end
    end

    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed self-checking bench for apb_slave_regfile: drives APB transfers on the
// falling edge and samples outputs 1 ns later, away from the rising edge.
`timescale 1ns/1ps
module tb_apb_slave_regfile;
    logic        Pclk = 1'b0;
    logic        Preset;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    always #5 Pclk = ~Pclk;

    apb_slave_regfile #(
        .SEL_IDX (0),
        .NUM_REGS(16),
        .ADDR_LSB(2)
    ) dut (
        .Pclk     (Pclk),
        .Preset   (Preset),
        .Pselx    (Pselx),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .proto_err(proto_err)
    );

    task automatic idle();
        @(negedge Pclk);
        Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge Pclk);
        Preset = 1'b1; Pselx = 3'b000; Penable = 1'b0;
        @(negedge Pclk);
        Preset = 1'b0;
        #1;
    endtask

    // Setup cycle then access cycle; rd is Prdata sampled in the access cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
        @(negedge Pclk);
        Pselx = 3'b001; Penable = 1'b0; Pwrite = w; Paddr = a; Pwdata = d;
        @(negedge Pclk);
        Penable = 1'b1;
        #1 rd = Prdata;
    endtask

    task automatic test_reset();
        Preset = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
        Paddr = '0; Pwdata = '0;
        repeat (3) @(negedge Pclk);
        Preset = 1'b0;
        #1;
        checks++; if (Prdata !== 32'h0) begin failures++; $display("FAIL reset_prdata: got %h expected %h", Prdata, 32'h0); end
        checks++; if (wr_count !== 16'h0) begin failures++; $display("FAIL reset_wr_count: got %h expected %h", wr_count, 16'h0); end
        checks++; if (rd_count !== 16'h0) begin failures++; $display("FAIL reset_rd_count: got %h expected %h", rd_count, 16'h0); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err: got %b expected %b", proto_err, 1'b0); end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        apply_reset();
        xfer(1'b1, 32'h08, 32'hA5A5_0001, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wr_prdata_zero: got %h expected %h", rd, 32'h0); end
        idle();
        xfer(1'b0, 32'h08, 32'h0, rd);
        checks++; if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_rd_data: got %h expected %h", rd, 32'hA5A5_0001); end
        idle();
        checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL wr_rd_wr_count: got %0d expected %0d", wr_count, 1); end
        checks++; if (rd_count !== 16'd1) begin failures++; $display("FAIL wr_rd_rd_count: got %0d expected %0d", rd_count, 1); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL wr_rd_proto_err: got %b expected %b", proto_err, 1'b0); end
        checks++; if (Prdata !== 32'h0) begin failures++; $display("FAIL idle_prdata: got %h expected %h", Prdata, 32'h0); end
        $display("test_write_read: read 0x08 -> %h", rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic [31:0] rd;
        addrs = '{32'h00, 32'h04, 32'h3C};
        datas = '{32'h1111_1111, 32'h2222_2222, 32'h3333_CCCC};
        apply_reset();
        for (int i = 0; i < 3; i++) xfer(1'b1, addrs[i], datas[i], rd);
        // Reads follow the last write with no idle cycle in between.
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, addrs[i], 32'h0, rd);
            checks++; if (rd !== datas[i]) begin failures++; $display("FAIL b2b_read%0d: got %h expected %h", i, rd, datas[i]); end
            $display("test_back_to_back: read %h -> %h", addrs[i], rd);
        end
        idle();
        checks++; if (wr_count !== 16'd3) begin failures++; $display("FAIL b2b_wr_count: got %0d expected %0d", wr_count, 3); end
        checks++; if (rd_count !== 16'd3) begin failures++; $display("FAIL b2b_rd_count: got %0d expected %0d", rd_count, 3); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL b2b_proto_err: got %b expected %b", proto_err, 1'b0); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        apply_reset();
        xfer(1'b1, 32'h40, 32'hFFFF_FFFF, rd);
        xfer(1'b0, 32'h40, 32'h0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_read_40: got %h expected %h", rd, 32'h0); end
        xfer(1'b0, 32'h00, 32'h0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_read_00: got %h expected %h", rd, 32'h0); end
        idle();
        checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL oor_wr_count: got %0d expected %0d", wr_count, 1); end
        checks++; if (rd_count !== 16'd2) begin failures++; $display("FAIL oor_rd_count: got %0d expected %0d", rd_count, 2); end
        $display("test_out_of_range: wr_count=%0d rd_count=%0d", wr_count, rd_count);
    endtask

    task automatic test_proto();
        logic [31:0] rd;
        // Penable without a setup phase.
        apply_reset();
        @(negedge Pclk);
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'hBAD0_0001;
        idle();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_no_setup: got %b expected %b", proto_err, 1'b1); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL proto_no_setup_wr: got %0d expected %0d", wr_count, 0); end
        $display("test_proto: no-setup proto_err=%b", proto_err);

        // Address changes between setup and access.
        apply_reset();
        @(negedge Pclk);
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'hDEAD_BEEF;
        @(negedge Pclk);
        Penable = 1'b1; Paddr = 32'h08;
        idle();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_addr_chg: got %b expected %b", proto_err, 1'b1); end
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL proto_addr_chg_wr: got %0d expected %0d", wr_count, 0); end
        xfer(1'b0, 32'h04, 32'h0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL proto_addr_chg_r04: got %h expected %h", rd, 32'h0); end
        xfer(1'b0, 32'h08, 32'h0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL proto_addr_chg_r08: got %h expected %h", rd, 32'h0); end
        idle();
        $display("test_proto: addr-change proto_err=%b", proto_err);

        // Penable held for a second cycle: first access commits, second flags.
        apply_reset();
        xfer(1'b1, 32'h0C, 32'h5555_AAAA, rd);
        @(negedge Pclk);
        idle();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_wait: got %b expected %b", proto_err, 1'b1); end
        checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL proto_wait_wr: got %0d expected %0d", wr_count, 1); end
        $display("test_proto: held-enable proto_err=%b", proto_err);

        // Transfer abandoned after setup.
        apply_reset();
        @(negedge Pclk);
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h00;
        idle();
        idle();
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_abandon: got %b expected %b", proto_err, 1'b1); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL proto_abandon_rd: got %0d expected %0d", rd_count, 0); end
        $display("test_proto: abandon proto_err=%b", proto_err);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        apply_reset();
        @(negedge Pclk);
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h0000_1234;
        @(negedge Pclk);
        Penable = 1'b1; Preset = 1'b1;
        @(negedge Pclk);
        Preset = 1'b0; Pselx = 3'b000; Penable = 1'b0;
        #1;
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL rstmid_wr_count: got %0d expected %0d", wr_count, 0); end
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL rstmid_rd_count: got %0d expected %0d", rd_count, 0); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rstmid_proto_err: got %b expected %b", proto_err, 1'b0); end
        xfer(1'b0, 32'h10, 32'h0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_read: got %h expected %h", rd, 32'h0); end
        idle();
        $display("test_reset_mid: read 0x10 -> %h", rd);
    endtask

    task automatic test_other_sel();
        logic [31:0] rd;
        apply_reset();
        @(negedge Pclk);
        Pselx = 3'b110; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'h7777_7777;
        @(negedge Pclk);
        Penable = 1'b1;
        idle();
        checks++; if (wr_count !== 16'd0) begin failures++; $display("FAIL othersel_wr_count: got %0d expected %0d", wr_count, 0); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL othersel_proto_err: got %b expected %b", proto_err, 1'b0); end
        xfer(1'b0, 32'h08, 32'h0, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL othersel_read: got %h expected %h", rd, 32'h0); end
        idle();
        $display("test_other_sel: read 0x08 -> %h", rd);
    endtask

    task automatic test_saturation();
        logic [31:0] rd;
        logic [15:0] exp_rd [4];
        exp_rd = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        apply_reset();
        // Preload the counters close to the top instead of running 65k transfers.
        @(negedge Pclk);
        force dut.rd_cnt_q = 16'hFFFD;
        force dut.wr_cnt_q = 16'hFFFE;
        @(negedge Pclk);
        release dut.rd_cnt_q;
        release dut.wr_cnt_q;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'h00, 32'h0, rd);
            idle();
            checks++; if (rd_count !== exp_rd[i]) begin failures++; $display("FAIL sat_rd_count%0d: got %h expected %h", i, rd_count, exp_rd[i]); end
            $display("test_saturation: read %0d rd_count=%h", i, rd_count);
        end
        for (int i = 0; i < 2; i++) begin
            xfer(1'b1, 32'h00, 32'h0, rd);
            idle();
            checks++; if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL sat_wr_count%0d: got %h expected %h", i, wr_count, 16'hFFFF); end
            $display("test_saturation: write %0d wr_count=%h", i, wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_proto();
        test_reset_mid();
        test_other_sel();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
